// File: rtl/sel_mux_seq_if.sv
// Bus bundle for sel_mux_seq: channel data, select/request controls and the tagged registered output.
// The master drives the requests; the slave (the selector) returns the registered beat.
interface sel_mux_seq_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] din;
    logic [SELW-1:0]      sel;
    logic                 en;
    logic                 start;
    logic                 hold;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic [SELW-1:0]      dout_ch;
    logic                 dout_last;
    logic                 busy;

    modport master (
        output din, sel, en, start, hold,
        input  dout, dout_valid, dout_ch, dout_last, busy
    );

    modport slave (
        input  din, sel, en, start, hold,
        output dout, dout_valid, dout_ch, dout_last, busy
    );
endinterface

// File: rtl/sel_mux_seq.sv
// Registered N-channel operand selector with an offset select map: DIRECT mode returns one
// channel per request, SCAN mode streams every channel in order starting from the mapped one.
module sel_mux_seq #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int SELW       = 2,
    parameter int SEL_OFFSET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    sel_mux_seq_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state, state_nxt;
    logic [SELW-1:0]   idx, idx_nxt;
    logic [SELW:0]     cnt, cnt_nxt;
    logic [SELW-1:0]   sel_ch;

    logic [WIDTH-1:0]  dout_p0, dout_p1;
    logic [SELW-1:0]   ch_p0, ch_p1;
    logic              vld_p0, vld_p1;
    logic              last_p0, last_p1;

    // Channel table padded to the full select range so any SELW-bit index is safe.
    logic [WIDTH-1:0]  chan [2**SELW];

    for (genvar i = 0; i < 2**SELW; i++) begin : g_chan
        if (i < NCH) begin : g_used
            assign chan[i] = bus.din[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[i] = '0;
        end
    end

    // Wider intermediate keeps sel+offset from overflowing before the modulo.
    function automatic logic [SELW-1:0] map_ch(input logic [SELW-1:0] s);
        logic [SELW:0] sum;
        sum = {1'b0, s} + (SELW+1)'(SEL_OFFSET);
        sum = sum % (SELW+1)'(NCH);
        return sum[SELW-1:0];
    endfunction

    function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] c);
        if (c == SELW'(NCH-1)) return '0;
        return c + SELW'(1);
    endfunction

    assign sel_ch = map_ch(bus.sel);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        dout_p0   = dout_p1;
        ch_p0     = ch_p1;
        vld_p0    = 1'b0;
        last_p0   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    dout_p0 = chan[sel_ch];
                    ch_p0   = sel_ch;
                    vld_p0  = 1'b1;
                    idx_nxt = next_ch(sel_ch);
                    cnt_nxt = (SELW+1)'(1);
                    if (NCH > 1) state_nxt = SCAN;
                    else         last_p0   = 1'b1;
                end else if (bus.en) begin
                    dout_p0 = chan[sel_ch];
                    ch_p0   = sel_ch;
                    vld_p0  = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.hold) begin
                    dout_p0 = chan[idx];
                    ch_p0   = idx;
                    vld_p0  = 1'b1;
                    idx_nxt = next_ch(idx);
                    cnt_nxt = cnt + (SELW+1)'(1);
                    if (cnt == (SELW+1)'(NCH-1)) begin
                        last_p0   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register stage: beat data and its tags update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            dout_p1 <= '0;
            ch_p1   <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            dout_p1 <= dout_p0;
            ch_p1   <= ch_p0;
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    assign bus.dout       = dout_p1;
    assign bus.dout_ch    = ch_p1;
    assign bus.dout_valid = vld_p1;
    assign bus.dout_last  = last_p1;
    assign bus.busy       = (state == SCAN);
endmodule

// File: tb/tb_sel_mux_seq.sv
// Directed bench for sel_mux_seq: default build plus NCH=3 and NCH=1 variants on one clock.
module tb_sel_mux_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sel_mux_seq_if #(.WIDTH(8), .NCH(4), .SELW(2)) if0 ();
    sel_mux_seq_if #(.WIDTH(8), .NCH(3), .SELW(2)) if3 ();
    sel_mux_seq_if #(.WIDTH(8), .NCH(1), .SELW(2)) if1 ();

    sel_mux_seq #(.WIDTH(8), .NCH(4), .SELW(2), .SEL_OFFSET(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    sel_mux_seq #(.WIDTH(8), .NCH(3), .SELW(2), .SEL_OFFSET(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    sel_mux_seq #(.WIDTH(8), .NCH(1), .SELW(2), .SEL_OFFSET(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic v, input logic [7:0] d,
                        input logic [1:0] c, input logic l, input logic b);
        chk({tag, ".valid"}, 32'(if0.dout_valid), 32'(v));
        chk({tag, ".dout"},  32'(if0.dout),       32'(d));
        chk({tag, ".ch"},    32'(if0.dout_ch),    32'(c));
        chk({tag, ".last"},  32'(if0.dout_last),  32'(l));
        chk({tag, ".busy"},  32'(if0.busy),       32'(b));
    endtask

    initial begin
        if0.din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        if3.din = {8'h32, 8'h31, 8'h30};
        if1.din = 8'h5A;
        {if3.sel, if3.en, if3.start, if3.hold} = '0;
        {if1.sel, if1.en, if1.start, if1.hold} = '0;

        // Reset held two cycles while requests are asserted
        rst_n = 1'b0; if0.en = 1'b1; if0.start = 1'b1; if0.sel = 2'd0; if0.hold = 1'b0;
        tick(); tick();
        chk0("rst", 0, 8'h00, 0, 0, 0);

        // DIRECT map, first response one cycle after release
        rst_n = 1'b1; if0.start = 1'b0; if0.en = 1'b1; if0.sel = 2'd0;
        tick(); chk0("dir0", 1, 8'hB1, 1, 0, 0);
        if0.sel = 2'd1; tick(); chk0("dir1", 1, 8'hC2, 2, 0, 0);
        if0.sel = 2'd2; tick(); chk0("dir2", 1, 8'hD3, 3, 0, 0);
        if0.sel = 2'd3; tick(); chk0("dir3", 1, 8'hA0, 0, 0, 0);
        if0.en = 1'b0;  tick(); chk0("dir_idle", 0, 8'hA0, 0, 0, 0);

        // SCAN from sel=2, then back-to-back restart in the last-beat cycle
        if0.start = 1'b1; if0.sel = 2'd2;
        tick(); chk0("scan_b0", 1, 8'hD3, 3, 0, 1);
        if0.start = 1'b0; if0.sel = 2'd0;
        tick(); chk0("scan_b1", 1, 8'hA0, 0, 0, 1);
        tick(); chk0("scan_b2", 1, 8'hB1, 1, 0, 1);
        tick(); chk0("scan_b3", 1, 8'hC2, 2, 1, 0);
        if0.start = 1'b1; if0.sel = 2'd2;
        tick(); chk0("scan2_b0", 1, 8'hD3, 3, 0, 1);
        if0.start = 1'b0;
        tick(); chk0("scan2_b1", 1, 8'hA0, 0, 0, 1);
        tick(); chk0("scan2_b2", 1, 8'hB1, 1, 0, 1);
        tick(); chk0("scan2_b3", 1, 8'hC2, 2, 1, 0);
        tick(); chk0("scan2_idle", 0, 8'hC2, 2, 0, 0);

        // Hold stalls the scan; mid-scan start/en/sel are ignored
        if0.start = 1'b1; if0.sel = 2'd3;
        tick(); chk0("hold_b0", 1, 8'hA0, 0, 0, 1);
        if0.start = 1'b0; if0.hold = 1'b1;
        tick(); chk0("hold_s1", 0, 8'hA0, 0, 0, 1);
        tick(); chk0("hold_s2", 0, 8'hA0, 0, 0, 1);
        if0.hold = 1'b0; if0.start = 1'b1; if0.en = 1'b1; if0.sel = 2'd0;
        tick(); chk0("hold_b1", 1, 8'hB1, 1, 0, 1);
        if0.start = 1'b0; if0.en = 1'b0;
        tick(); chk0("hold_b2", 1, 8'hC2, 2, 0, 1);
        tick(); chk0("hold_b3", 1, 8'hD3, 3, 1, 0);

        // start and en together in IDLE: start wins
        if0.start = 1'b1; if0.en = 1'b1; if0.sel = 2'd0;
        tick(); chk0("prio_b0", 1, 8'hB1, 1, 0, 1);
        if0.start = 1'b0; if0.en = 1'b0;
        tick(); chk0("prio_b1", 1, 8'hC2, 2, 0, 1);
        tick(); chk0("prio_b2", 1, 8'hD3, 3, 0, 1);
        tick(); chk0("prio_b3", 1, 8'hA0, 0, 1, 0);

        // Reset after beat 2 aborts with no last beat
        if0.start = 1'b1; if0.sel = 2'd0;
        tick(); chk0("abort_b1", 1, 8'hB1, 1, 0, 1);
        if0.start = 1'b0;
        tick(); chk0("abort_b2", 1, 8'hC2, 2, 0, 1);
        rst_n = 1'b0;
        tick(); chk0("abort_rst", 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        tick(); chk0("abort_after", 0, 8'h00, 0, 0, 0);

        // NCH=3 select wrap
        if3.en = 1'b1; if3.sel = 2'd2;
        tick();
        chk("n3_sel2.valid", 32'(if3.dout_valid), 32'd1);
        chk("n3_sel2.dout",  32'(if3.dout),       32'h30);
        chk("n3_sel2.ch",    32'(if3.dout_ch),    32'd0);
        if3.sel = 2'd3;
        tick();
        chk("n3_sel3.dout",  32'(if3.dout),       32'h31);
        chk("n3_sel3.ch",    32'(if3.dout_ch),    32'd1);
        if3.en = 1'b0;

        // NCH=1 scan is a single last beat without busy
        if1.start = 1'b1; if1.sel = 2'd2;
        tick();
        chk("n1_scan.valid", 32'(if1.dout_valid), 32'd1);
        chk("n1_scan.dout",  32'(if1.dout),       32'h5A);
        chk("n1_scan.ch",    32'(if1.dout_ch),    32'd0);
        chk("n1_scan.last",  32'(if1.dout_last),  32'd1);
        chk("n1_scan.busy",  32'(if1.busy),       32'd0);
        if1.start = 1'b0;
        tick();
        chk("n1_idle.valid", 32'(if1.dout_valid), 32'd0);
        chk("n1_idle.last",  32'(if1.dout_last),  32'd0);
        chk("n1_idle.busy",  32'(if1.busy),       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
